led_matrix_scan_ctrl: RTL
=========================

// Module: led_matrix_scan_ctrl
// PURPOSE
//  Row-multiplexed scan controller for the N x N LED matrix.
//  - Holds a double-buffered frame bitmap and drives one row at a time: active-low row
//    selects, active-high column data.
//  - Inserts blanking between rows to suppress ghosting.
//  - Accepts new frames over a valid/ready handshake and swaps them in only at frame boundaries.
//  - Sits between pattern producers and the matrix pins.
// PARAMETERS
//  N      15    matrix dimension (rows = cols = N)
//  DWELL  1024  clocks each row is driven per frame (>=1)
//  BLANK  4     clocks all rows are off before each row is driven (>=1)
// PORTS
//  clk          in   1      system clock, rising edge
//  rst_n        in   1      asynchronous active-low reset
//  en           in   1      scan enable; sampled only at row boundaries
//  load_valid   in   1      producer has a frame on load_data
//  load_ready   out  1      controller can accept a frame
//  load_data    in   N*N    frame bitmap; pixel (row y, col z) = bit y*N+z, 1 = lit
//  row_n        out  N      row selects, active-low, at most one low at a time
//  col          out  N      column drive, active-high
//  frame_start  out  1      one-cycle pulse when row 0 enters BLANK
//  busy         out  1      1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, immediate):
//    row_n = all 1, col = 0, load_ready = 1, frame_start = 0, busy = 0
//    front = 0, back = 0, pending = 0, row = 0, counter = 0, state = IDLE
//  Registered outputs: row_n, col, frame_start and busy are registered and change one clock
//    after the state decision.
//  Load handshake:
//    - Transfer occurs on the cycle where load_valid & load_ready.
//    - On transfer: back <= load_data, pending <= 1.
//    - load_ready = ~pending.
//    - load_data is don't-care when no transfer occurs.
//  FSM states: IDLE, BLANK, DRIVE.
//    IDLE : row_n = all 1, col = 0.
//           en = 1 -> BLANK with row = 0 and counter = 0.
//           Buffer swap happens on this transition if pending.
//           frame_start pulses.
//    BLANK: row_n = all 1, col = 0 for BLANK clocks, then -> DRIVE with counter = 0.
//    DRIVE: row_n[row] = 0, col = front[row*N +: N] for DWELL clocks.
//           At the end of the row:
//           - row < N-1, en = 1: row++ -> BLANK.
//           - row = N-1, en = 1: frame end.
//               Swap if pending (front <= back, pending <= 0).
//               row = 0 -> BLANK.
//               frame_start pulses.
//           - en = 0: -> IDLE, row = 0, no swap, outputs dark.
//  en = 0 mid-row: the current row completes its full DWELL first; no truncation.
//  Swap and load in the same cycle: impossible, because load_ready = 0 while pending.
//    load_ready returns to 1 on the clock after the swap.
//  Front buffer: changes only at a swap, so a displayed frame is never torn.
//  Counter: ceil(log2(max(DWELL,BLANK))) bits; terminal count = DWELL-1 or BLANK-1;
//    no wrap beyond that.
//  Frame period: N*(BLANK+DWELL) clocks.
// STRUCTURE
//  Package led_matrix_pkg:
//    - state enum {IDLE, BLANK, DRIVE}
//    - default N
//    - function pix_idx(y,z) = y*N+z
//  Sub-module led_scan_timer:
//    - loadable down-counter
//    - inputs: start, len; output: done pulse at terminal count
//    - shared by BLANK and DRIVE
//  Top-level contents: FSM, row index, two N*N buffers, pending flag, output registers.
// TESTING (bench N=4, DWELL=8, BLANK=2)
//  1. Reset mid-DRIVE (rst_n low for 1 ns between edges)
//       -> row_n = 4'b1111, col = 0, load_ready = 1 immediately.
//  2. Load 16'h8421, en = 1
//       -> rows 0..3 show col = 1,2,4,8.
//       -> row_n = 1110, 1101, 1011, 0111, each low for 8 clocks, 2 dark clocks between.
//       -> frame_start every 40 clocks.
//  3. Load 16'hFFFF mid-frame
//       -> load_ready = 0 until frame end.
//       -> current frame unchanged; next frame all cols = 4'hF.
//       -> load_ready = 1 one clock after the swap.
//  4. Hold load_valid continuously with alternating data
//       -> exactly one accept per frame; each accepted frame displayed for exactly one frame.
//  5. Drop en during row 1
//       -> row 1 completes its 8 clocks, then IDLE, busy = 0, dark.
//       -> re-enable restarts at row 0 with a frame_start pulse.
//  6. Every cycle: assert at most one row_n bit low.
//       -> in BLANK and IDLE, col = 0 and row_n = all 1.

Source files
------------

// File: rtl/led_matrix_pkg.sv
// led_matrix_pkg: shared scan-controller types, defaults and index helpers
package led_matrix_pkg;

    typedef enum logic [1:0] {ST_IDLE, ST_BLANK, ST_DRIVE} state_e;

    localparam int N_DEF = 15;

    function automatic int pix_idx(input int y, input int z, input int n);
        return y * n + z;
    endfunction

    // Bit width able to hold 0..v-1, never below 1.
    function automatic int clog2_min1(input int v);
        return (v > 1) ? $clog2(v) : 1;
    endfunction

endpackage

// File: rtl/led_scan_timer.sv
// led_scan_timer: loadable down-counter shared by the BLANK and DRIVE phases
//   clk, rst_n : clock, async active-low reset
//   start_i    : load len_i into the counter
//   len_i      : terminal count (phase length minus one)
//   done_o     : high while the counter sits at zero (last cycle of the phase)
module led_scan_timer #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start_i,
    input  logic [W-1:0] len_i,
    output logic         done_o
);

    logic [W-1:0] cnt_q, cnt_d;

    // Counts down and parks at zero; no wrap.
    assign cnt_d  = start_i ? len_i : (cnt_q != '0) ? cnt_q - W'(1) : cnt_q;
    assign done_o = (cnt_q == '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

endmodule

// File: rtl/led_matrix_scan_ctrl.sv
// led_matrix_scan_ctrl: row-multiplexed N x N LED scan controller with double-buffered frames
//   clk, rst_n              : clock, async active-low reset
//   en                      : scan enable, honoured at row boundaries
//   load_valid/load_ready   : frame handshake, load_data holds pixel (y,z) at bit y*N+z
//   row_n                   : active-low row selects, col : active-high column drive
//   frame_start             : one-cycle pulse as row 0 enters blanking
//   busy                    : controller is scanning
module led_matrix_scan_ctrl
    import led_matrix_pkg::*;
#(
    parameter int N     = N_DEF,
    parameter int DWELL = 1024,
    parameter int BLANK = 4
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           en,
    input  logic           load_valid,
    output logic           load_ready,
    input  logic [N*N-1:0] load_data,
    output logic [N-1:0]   row_n,
    output logic [N-1:0]   col,
    output logic           frame_start,
    output logic           busy
);

    localparam int MAXL = (DWELL > BLANK) ? DWELL : BLANK;
    localparam int CW   = clog2_min1(MAXL);
    localparam int RW   = clog2_min1(N);
    localparam int IW   = clog2_min1(N * N);
    localparam logic [CW-1:0] BLANK_TC = CW'(BLANK - 1);
    localparam logic [CW-1:0] DWELL_TC = CW'(DWELL - 1);
    localparam logic [RW-1:0] LAST_ROW = RW'(N - 1);

    state_e          state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [N*N-1:0]  front_q, front_d, back_q, back_d;
    logic            pending_q, pending_d;
    logic [N-1:0]    row_n_q, row_n_d, col_q, col_d;
    logic            fs_q, busy_q;
    logic            tmr_start, tmr_done, swap, frame_go, xfer;
    logic [CW-1:0]   tmr_len;
    logic [IW-1:0]   base;

    led_scan_timer #(.W(CW)) u_timer (
        .clk    (clk),
        .rst_n  (rst_n),
        .start_i(tmr_start),
        .len_i  (tmr_len),
        .done_o (tmr_done)
    );

    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        tmr_start = 1'b0;
        tmr_len   = BLANK_TC;
        swap      = 1'b0;
        frame_go  = 1'b0;
        case (state_q)
            ST_IDLE: if (en) begin
                state_d   = ST_BLANK;
                row_d     = '0;
                tmr_start = 1'b1;
                swap      = pending_q;
                frame_go  = 1'b1;
            end
            ST_BLANK: if (tmr_done) begin
                state_d   = ST_DRIVE;
                tmr_start = 1'b1;
                tmr_len   = DWELL_TC;
            end
            ST_DRIVE: if (tmr_done) begin
                // en only matters here, once the row has had its full dwell.
                if (!en) begin
                    state_d = ST_IDLE;
                    row_d   = '0;
                end else begin
                    state_d   = ST_BLANK;
                    tmr_start = 1'b1;
                    if (row_q == LAST_ROW) begin
                        row_d    = '0;
                        swap     = pending_q;
                        frame_go = 1'b1;
                    end else begin
                        row_d = row_q + RW'(1);
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Swap needs pending=1 and transfer needs pending=0, so they never collide.
        xfer      = load_valid & ~pending_q;
        pending_d = swap ? 1'b0 : xfer ? 1'b1 : pending_q;
        back_d    = xfer ? load_data : back_q;
        front_d   = swap ? back_q : front_q;
        // Outputs are computed from the next state so they line up with state_q.
        base      = IW'(pix_idx(int'(row_d), 0, N));
        row_n_d   = (state_d == ST_DRIVE) ? ~(N'(1) << row_d) : '1;
        col_d     = (state_d == ST_DRIVE) ? front_q[base +: N] : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            row_q     <= '0;
            front_q   <= '0;
            back_q    <= '0;
            pending_q <= 1'b0;
            row_n_q   <= '1;
            col_q     <= '0;
            fs_q      <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            front_q   <= front_d;
            back_q    <= back_d;
            pending_q <= pending_d;
            row_n_q   <= row_n_d;
            col_q     <= col_d;
            fs_q      <= frame_go;
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign load_ready  = ~pending_q;
    assign row_n       = row_n_q;
    assign col         = col_q;
    assign frame_start = fs_q;
    assign busy        = busy_q;

endmodule
